normaliza_arredonda: RTL



---
 rtl/normaliza_arredonda_if.sv | 26 ++
 rtl/normaliza_arredonda.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/normaliza_arredonda_if.sv
// Operand/result bundle for the normalise-and-round stage.
// master drives operands and start; slave returns the packed result and status.
interface normaliza_arredonda_if #(
    parameter int unsigned LARG_EXP  = 8,
    parameter int unsigned LARG_FRAC = 23
);
    logic                          start;
    logic                          sinal;
    logic [LARG_EXP-1:0]           expoente;
    logic [LARG_FRAC+3:0]          mantissa;
    logic                          busy;
    logic                          done;
    logic [LARG_EXP+LARG_FRAC:0]   resultado;
    logic                          overflow;
    logic                          underflow;

    modport master (
        output start, sinal, expoente, mantissa,
        input  busy, done, resultado, overflow, underflow
    );

    modport slave (
        input  start, sinal, expoente, mantissa,
        output busy, done, resultado, overflow, underflow
    );
endinterface

// File: rtl/normaliza_arredonda.sv
// Sequential normalise / round-to-nearest-even / pack stage for the single-precision
// add/multiply datapath. Normalises one bit per cycle; no denormals.
module normaliza_arredonda #(
    parameter int unsigned LARG_EXP  = 8,
    parameter int unsigned LARG_FRAC = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    normaliza_arredonda_if.slave  bus
);
    localparam int unsigned EW = LARG_EXP + 2;
    localparam int unsigned MW = LARG_FRAC + 4;
    localparam int unsigned RW = 1 + LARG_EXP + LARG_FRAC;

    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << LARG_EXP) - 1);
    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StNormaliza,
        StArredonda,
        StRenormaliza,
        StFim
    } state_e;

    state_e                state_q;
    logic                  sinal_q;
    logic signed [EW-1:0]  e_q;
    logic [MW-1:0]         m_q;
    logic [RW-1:0]         resultado_q;
    logic                  done_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic signed [EW-1:0]  e_in;
    logic signed [EW-1:0]  e_inc;
    logic signed [EW-1:0]  e_dec;
    logic                  inc;
    logic [LARG_FRAC+1:0]  soma;

    always_comb begin
        e_in  = $signed({2'b00, bus.expoente});
        e_inc = e_q + E_ONE;
        e_dec = e_q - E_ONE;
        // Round to nearest, ties to even: guard set and (sticky or LSB odd).
        inc   = m_q[1] & (m_q[0] | m_q[2]);
        soma  = {1'b0, m_q[MW-2:2]} + {{(LARG_FRAC + 1){1'b0}}, inc};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            sinal_q     <= 1'b0;
            e_q         <= '0;
            m_q         <= '0;
            resultado_q <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        sinal_q     <= bus.sinal;
                        e_q         <= e_in;
                        m_q         <= bus.mantissa;
                        overflow_q  <= 1'b0;
                        underflow_q <= 1'b0;
                        if (bus.mantissa == '0) begin
                            resultado_q <= {bus.sinal, {(RW - 1){1'b0}}};
                            state_q     <= StFim;
                        end else if (e_in >= E_MAX) begin
                            resultado_q <= {bus.sinal, {LARG_EXP{1'b1}}, {LARG_FRAC{1'b0}}};
                            overflow_q  <= 1'b1;
                            state_q     <= StFim;
                        end else if (e_in <= E_ZERO) begin
                            resultado_q <= {bus.sinal, {(RW - 1){1'b0}}};
                            underflow_q <= 1'b1;
                            state_q     <= StFim;
                        end else begin
                            state_q <= StNormaliza;
                        end
                    end
                end
                StNormaliza: begin
                    if (m_q[MW-1]) begin
                        // Right shift folds the dropped bit into sticky.
                        m_q <= {1'b0, m_q[MW-1:2], m_q[1] | m_q[0]};
                        e_q <= e_inc;
                        if (e_inc >= E_MAX) begin
                            resultado_q <= {sinal_q, {LARG_EXP{1'b1}}, {LARG_FRAC{1'b0}}};
                            overflow_q  <= 1'b1;
                            state_q     <= StFim;
                        end
                    end else if (!m_q[MW-2]) begin
                        m_q <= m_q << 1;
                        e_q <= e_dec;
                        if (e_dec <= E_ZERO) begin
                            resultado_q <= {sinal_q, {(RW - 1){1'b0}}};
                            underflow_q <= 1'b1;
                            state_q     <= StFim;
                        end
                    end else begin
                        state_q <= StArredonda;
                    end
                end
                StArredonda: begin
                    m_q[MW-2:2] <= soma[LARG_FRAC:0];
                    if (soma[LARG_FRAC+1]) begin
                        state_q <= StRenormaliza;
                    end else begin
                        resultado_q <= {sinal_q, e_q[LARG_EXP-1:0], soma[LARG_FRAC-1:0]};
                        state_q     <= StFim;
                    end
                end
                StRenormaliza: begin
                    m_q <= {2'b01, {(MW - 2){1'b0}}};
                    e_q <= e_inc;
                    if (e_inc >= E_MAX) begin
                        resultado_q <= {sinal_q, {LARG_EXP{1'b1}}, {LARG_FRAC{1'b0}}};
                        overflow_q  <= 1'b1;
                    end else begin
                        resultado_q <= {sinal_q, e_inc[LARG_EXP-1:0], {LARG_FRAC{1'b0}}};
                    end
                    state_q <= StFim;
                end
                StFim: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;
    assign bus.resultado = resultado_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule
